// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//   Parametrised up/down modulo counter with synchronous load and a registered
//   one-cycle wrap pulse. It is intended as a general timebase or event counter.
//   The count range is 0..MODULUS-1, and the counter never produces a value
//   outside that range.
//
// Parameters
//   NUM_BITS  width of count and load_value
//   MODULUS   count range 0..MODULUS-1 (2 <= MODULUS <= 2**NUM_BITS)
//   PRESCALE  number of enabled cycles per count step
//             (only used when COUNTER_PRESCALE_EN is defined); must be >= 1
//
// Optional feature
//   COUNTER_PRESCALE_EN  When this macro is defined, the build adds a prescaler
//                        that counts enabled cycles. In that build the count
//                        steps once every PRESCALE enabled cycles. When the
//                        macro is undefined, the count steps on every enabled
//                        cycle.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   enable      in   count when high, hold when low
//   up          in   1 = increment, 0 = decrement
//   load        in   synchronous load of load_value (clamped to MODULUS-1)
//   load_value  in   value to load
//   count       out  registered count
//   wrap        out  registered 1-cycle pulse; high in the cycle the wrapped
//                    count value appears
//   at_limit    out  combinational: count == MODULUS-1 (up=1) or count == 0 (up=0)
//
// Per-cycle priority: reset > load > enable step > hold.
// -----------------------------------------------------------------------------
module updown_counter #(
    parameter int NUM_BITS = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                up,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_value,
    output logic [NUM_BITS-1:0] count,
    output logic                wrap,
    output logic                at_limit
);

    localparam logic [NUM_BITS-1:0] MAX_COUNT = NUM_BITS'(MODULUS - 1);

    // High on the enabled cycles where the count actually moves.
    logic step_now;

`ifdef COUNTER_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre;

    assign step_now = enable && (pre == PRE_LAST);

    // The prescaler counts enabled cycles and freezes while enable is low.
    // Reset and load both restart the phase.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            pre <= '0;
        end else if (enable) begin
            pre <= step_now ? '0 : pre + PRE_W'(1);
        end
    end
`else
    // PRESCALE only matters when the prescaler is built in.
    localparam int unused_prescale = PRESCALE;

    assign step_now = enable;
`endif

    // Next value for a step in each direction, including the modulo wrap.
    logic [NUM_BITS-1:0] count_inc;
    logic [NUM_BITS-1:0] count_dec;
    logic [NUM_BITS-1:0] load_clamped;

    assign count_inc    = (count == MAX_COUNT) ? '0 : count + NUM_BITS'(1);
    assign count_dec    = (count == '0) ? MAX_COUNT : count - NUM_BITS'(1);
    assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (step_now) begin
            if (up) begin
                count <= count_inc;
                wrap  <= (count == MAX_COUNT);
            end else begin
                count <= count_dec;
                wrap  <= (count == '0);
            end
        end else begin
            // Hold cycles, and prescaler cycles that do not step, clear the pulse.
            wrap <= 1'b0;
        end
    end

    // at_limit depends only on count and the current direction. It is not
    // gated by enable.
    assign at_limit = up ? (count == MAX_COUNT) : (count == '0);

endmodule

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
//   Self-checking bench for updown_counter with NUM_BITS=8 and MODULUS=200.
//   A behavioural reference model tracks the count using modulo arithmetic.
//   Expected counts go through an expected queue. Directed sequences cover
//   reset, wrap in both directions, load clamping, hold and reset mid-count.
//   The prescaler sequence runs only when COUNTER_PRESCALE_EN is defined.
//   A randomized phase follows the directed sequences.
// -----------------------------------------------------------------------------
module tb_updown_counter;

    localparam int NB = 8;
    localparam int M  = 200;
`ifdef COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          up;
    logic          load;
    logic [NB-1:0] load_value;
    logic [NB-1:0] count;
    logic          wrap;
    logic          at_limit;

    always #1 clk = ~clk;

    updown_counter #(
        .NUM_BITS (NB),
        .MODULUS  (M),
        .PRESCALE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .wrap       (wrap),
        .at_limit   (at_limit)
    );

    // ---------------- scoreboard ----------------
    logic [NB-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int m_count = 0;
    int m_wrap  = 0;
    int m_phase = 0;

    task automatic model_step(input bit r, input bit l, input bit e,
                              input bit u, input int lv);
        if (r) begin
            m_count = 0; m_wrap = 0; m_phase = 0;
        end else if (l) begin
            m_count = (lv > M - 1) ? M - 1 : lv;
            m_wrap  = 0;
            m_phase = 0;
        end else if (e) begin
            if (m_phase == PS - 1) begin
                m_phase = 0;
                if (u) begin
                    m_wrap  = (m_count == M - 1) ? 1 : 0;
                    m_count = (m_count + 1) % M;
                end else begin
                    m_wrap  = (m_count == 0) ? 1 : 0;
                    m_count = (m_count + M - 1) % M;
                end
            end else begin
                m_phase = m_phase + 1;
                m_wrap  = 0;
            end
        end else begin
            m_wrap = 0;
        end
        exp_q.push_back(NB'(m_count));
    endtask

    // ---------------- driver ----------------
    // Drive the inputs, then take one clock edge and update the model. Outputs
    // are checked on the following falling edge.
    task automatic drive_cycle(input bit r, input bit l, input bit e,
                               input bit u, input int lv);
        reset = r; load = l; enable = e; up = u; load_value = NB'(lv);
        @(posedge clk);
        model_step(r, l, e, u, lv);
        #1;
        check("count", int'(count), int'(exp_q.pop_front()));
        check("wrap", int'(wrap), m_wrap);
        check("at_limit", int'(at_limit),
              u ? ((m_count == M - 1) ? 1 : 0) : ((m_count == 0) ? 1 : 0));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; up = 1'b1; load = 1'b0; load_value = '0;

        // Reset held for 5 cycles with enable high, then released.
        for (int i = 0; i < 5; i++) drive_cycle(1, 0, 1, 1, 0);
        check("t1_reset_count", int'(count), 0);
        drive_cycle(0, 0, 1, 1, 0);
`ifndef COUNTER_PRESCALE_EN
        check("t1_first_step", int'(count), 1);
`endif

        // Wrap going up.
        drive_cycle(0, 1, 0, 1, 198);
        check("t2_load", int'(count), 198);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 1, 0);
`ifndef COUNTER_PRESCALE_EN
        check("t2_end", int'(count), 1);
`endif

        // Wrap going down.
        drive_cycle(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 0, 0);
`ifndef COUNTER_PRESCALE_EN
        check("t3_end", int'(count), 198);
`endif

        // Load clamping, then load and enable asserted together.
        drive_cycle(0, 1, 0, 1, 250);
        check("t4_clamp", int'(count), 199);
        drive_cycle(0, 1, 1, 1, 10);
        check("t4_load_beats_enable", int'(count), 10);

        // Count to 50, hold with enable low, resume, then reset mid-count.
        drive_cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 50 * PS; i++) drive_cycle(0, 0, 1, 1, 0);
        check("t5_reach_50", int'(count), 50);
        for (int i = 0; i < 10; i++) drive_cycle(0, 0, 0, 1, 0);
        check("t5_hold", int'(count), 50);
        for (int i = 0; i < PS; i++) drive_cycle(0, 0, 1, 1, 0);
        check("t5_resume", int'(count), 51);
        drive_cycle(1, 0, 1, 1, 0);
        check("t5_mid_reset", int'(count), 0);

`ifdef COUNTER_PRESCALE_EN
        // Prescaler: 12 enabled cycles from 0 give 3 steps. An enable gap
        // keeps the phase, and a load restarts it.
        for (int i = 0; i < 12; i++) drive_cycle(0, 0, 1, 1, 0);
        check("t6_three_steps", int'(count), 3);
        drive_cycle(0, 0, 1, 1, 0);
        drive_cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(0, 0, 1, 1, 0);
        check("t6_gap_no_step", int'(count), 3);
        drive_cycle(0, 0, 1, 1, 0);
        check("t6_gap_step", int'(count), 4);
        drive_cycle(0, 0, 1, 1, 0);
        drive_cycle(0, 1, 0, 1, 20);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 1, 1, 0);
        check("t6_load_phase_hold", int'(count), 20);
        drive_cycle(0, 0, 1, 1, 0);
        check("t6_load_phase_step", int'(count), 21);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 99) < 2,
                        $urandom_range(0, 99) < 8,
                        $urandom_range(0, 99) < 85,
                        1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
